// File: rtl/tick_monitor_pkg.sv
// Shared types for the slow-clock tick monitor.
// Included by tick_monitor and sync_edge_det.
package tick_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with registered rise (and, with
// TICK_MONITOR_DUTY_EN, fall and level) outputs.
module sync_edge_det
  import tick_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
`ifdef TICK_MONITOR_DUTY_EN
  output logic level,
  output logic fall,
`endif
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   s_out;

  assign s_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= s_out;
      rise   <= s_out & ~hist_q;
    end
  end

`ifdef TICK_MONITOR_DUTY_EN
  // level is aligned with rise/fall: high on the rise cycle
  assign level = hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall <= 1'b0;
    end else begin
      fall <= ~s_out & hist_q;
    end
  end
`endif

endmodule

// File: rtl/tick_monitor.sv
// Slow-clock receiver: tick, period, lock and error status.
// Optional high_time output under TICK_MONITOR_DUTY_EN.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int EXP_PERIOD  = 500000,
  parameter int TOL         = 5000,
  parameter int LOCK_N      = 4,
  parameter int CNT_W       = 25,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slow_clk_in,
  output logic                 tick,
  output logic [CNT_W-1:0]     period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 err_fast,
  output logic                 err_slow,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef TICK_MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0]     high_time
`endif
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LO_LIM =
    CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_LIM =
    CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] STALL_CNT =
    CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

  logic rise;

`ifdef TICK_MONITOR_DUTY_EN
  logic level;
  logic fall;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (slow_clk_in),
`ifdef TICK_MONITOR_DUTY_EN
    .level(level),
    .fall (fall),
`endif
    .rise (rise)
  );

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [GOOD_W-1:0]  good, good_n;
  logic [CNT_W-1:0]   period_n;
  logic               pv_n, fast_n, slow_n;
  logic               in_range, too_fast, stall;

  assign in_range = (cnt >= LO_LIM) && (cnt <= HI_LIM);
  assign too_fast = cnt < LO_LIM;
  // a tick on the timeout cycle takes priority over the stall
  assign stall    = (state != WAIT) && !rise &&
                    (cnt == STALL_CNT);

  always_comb begin
    state_n  = state;
    good_n   = good;
    period_n = period;
    pv_n     = 1'b0;
    fast_n   = 1'b0;
    slow_n   = 1'b0;
    unique case (state)
      WAIT: begin
        if (rise) state_n = ACQ;
      end
      ACQ, LOCK: begin
        if (rise) begin
          period_n = cnt;
          pv_n     = 1'b1;
          if (in_range) begin
            if (state == ACQ) begin
              good_n = good + 1'b1;
              if (good_n == LOCK_V) state_n = LOCK;
            end
          end else begin
            good_n  = '0;
            fast_n  = too_fast;
            slow_n  = ~too_fast;
            state_n = ACQ;
          end
        end else if (stall) begin
          slow_n  = 1'b1;
          good_n  = '0;
          state_n = WAIT;
        end
      end
      default: begin
        state_n = WAIT;
        good_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT;
      good         <= '0;
      cnt          <= '0;
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state        <= state_n;
      good         <= good_n;
      tick         <= rise;
      period       <= period_n;
      period_valid <= pv_n;
      locked       <= (state_n == LOCK);
      err_fast     <= fast_n;
      err_slow     <= slow_n;
      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if ((fast_n || slow_n) && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef TICK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] hi_acc;
  logic [CNT_W-1:0] hi_cap;

  // hi_acc counts from the rise cycle; fall freezes it into hi_cap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_acc    <= '0;
      hi_cap    <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        hi_acc <= CNT_W'(1);
      end else if (level && (hi_acc != CNT_MAX)) begin
        hi_acc <= hi_acc + 1'b1;
      end
      if (fall) hi_cap <= hi_acc;
      if (pv_n) high_time <= hi_cap;
    end
  end
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Randomized bench for tick_monitor with a cycle-indexed
// behavioural reference model and literal spot checks.
module tb_tick_monitor;

  localparam int EXP   = 100;
  localparam int TOL   = 5;
  localparam int LOCKN = 3;
  localparam int CW    = 12;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow = 1'b0;
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          err_fast;
  logic          err_slow;
  logic [7:0]    err_cnt;
`ifdef TICK_MONITOR_DUTY_EN
  logic [CW-1:0] high_time;
`endif

  tick_monitor #(
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_N     (LOCKN),
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk_in (slow),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err_fast    (err_fast),
    .err_slow    (err_slow),
    .err_cnt     (err_cnt)
`ifdef TICK_MONITOR_DUTY_EN
    ,
    .high_time   (high_time)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nprint = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %0d want %0d t=%0t",
                 nm, got, exp, $time);
      end
    end
  endtask

  // Reference model: input sampled at clk edge n is visible
  // as an event SS+1 edges later; period = edges between events.
  bit h [0:SS+2];
  int n, last_evt, phase, good, hi, since;
  bit evt;
  bit m_tick, m_pv, m_locked, m_fast, m_slow;
  int m_period, m_errs, m_high;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (h[i]) h[i] = 1'b0;
      n = 0; last_evt = 0; phase = 0; good = 0; hi = 0;
      m_tick = 0; m_pv = 0; m_locked = 0;
      m_fast = 0; m_slow = 0;
      m_period = 0; m_errs = 0; m_high = 0;
    end else begin
      for (int i = SS + 2; i > 0; i--) h[i] = h[i-1];
      h[0] = slow;
      n++;
      evt = h[SS+1] && !h[SS+2];
      since = n - last_evt;
      m_tick = evt;
      m_pv = 0; m_fast = 0; m_slow = 0;
      if (evt) begin
        if (phase != 0) begin
          m_period = since;
          m_pv = 1;
          m_high = hi;
          if (since >= EXP - TOL && since <= EXP + TOL) begin
            if (phase == 1) begin
              good++;
              if (good == LOCKN) phase = 2;
            end
          end else begin
            good = 0;
            phase = 1;
            if (since < EXP - TOL) m_fast = 1;
            else m_slow = 1;
          end
        end else begin
          phase = 1;
        end
        last_evt = n;
        hi = 0;
      end else if (phase != 0 && since == EXP + TOL + 1) begin
        m_slow = 1;
        good = 0;
        phase = 0;
      end
      if (h[SS+1]) hi++;
      if ((m_fast || m_slow) && m_errs < 255) m_errs++;
      m_locked = (phase == 2);
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("tick", 32'(tick), 32'(m_tick));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("period", 32'(period), m_period);
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err_fast", 32'(err_fast), 32'(m_fast));
      chk("err_slow", 32'(err_slow), 32'(m_slow));
      chk("err_cnt", 32'(err_cnt), m_errs);
`ifdef TICK_MONITOR_DUTY_EN
      chk("high_time", 32'(high_time), m_high);
`endif
    end
  end

  task automatic run_period(input int p, input int hgh);
    slow = 1'b1;
    repeat (hgh) @(negedge clk);
    slow = 1'b0;
    repeat (p - hgh) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " tick"}, 32'(tick), 0);
    chk({tag, " period"}, 32'(period), 0);
    chk({tag, " pv"}, 32'(period_valid), 0);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " fast"}, 32'(err_fast), 0);
    chk({tag, " slow"}, 32'(err_slow), 0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 0);
`ifdef TICK_MONITOR_DUTY_EN
    chk({tag, " high_time"}, 32'(high_time), 0);
`endif
  endtask

  initial begin
    int p, hg;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    repeat (5) run_period(100, 50);
    chk("lock1 locked", 32'(locked), 1);
    chk("lock1 period", 32'(period), 100);
    chk("lock1 err_cnt", 32'(err_cnt), 0);
`ifdef TICK_MONITOR_DUTY_EN
    chk("duty50", 32'(high_time), 50);
`endif

    run_period(90, 45);
    run_period(100, 50);
    chk("p90 err_cnt", 32'(err_cnt), 1);
    chk("p90 locked", 32'(locked), 0);
    chk("p90 period", 32'(period), 90);
    repeat (3) run_period(100, 30);
    chk("relock", 32'(locked), 1);

    run_period(95, 40);
    run_period(105, 60);
    run_period(100, 50);
    chk("edge95/105 err_cnt", 32'(err_cnt), 1);
    chk("edge105 period", 32'(period), 105);
    chk("edge95/105 locked", 32'(locked), 1);
    run_period(94, 40);
    run_period(106, 60);
    run_period(100, 50);
    chk("edge94/106 err_cnt", 32'(err_cnt), 3);
    chk("edge106 period", 32'(period), 106);
    repeat (4) run_period(100, 50);
    chk("relock2", 32'(locked), 1);

    slow = 1'b1;
    repeat (50) @(negedge clk);
    slow = 1'b0;
    repeat (250) @(negedge clk);
    chk("stall locked", 32'(locked), 0);
    chk("stall err_cnt", 32'(err_cnt), 4);
    repeat (5) run_period(100, 50);
    chk("post-stall lock", 32'(locked), 1);

    repeat (300) run_period(90, 20);
    run_period(100, 50);
    chk("saturate", 32'(err_cnt), 255);

    repeat (60) begin
      p = $urandom_range(85, 115);
      hg = $urandom_range(1, p - 1);
      run_period(p, hg);
    end

    repeat (5) run_period(100, 50);
    chk("pre-rst locked", 32'(locked), 1);
    slow = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async rst");
    slow = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) run_period(100, 50);
    chk("post-rst lock", 32'(locked), 1);
    chk("post-rst err_cnt", 32'(err_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
